// File: rtl/morse_symbol_sequencer.sv
// Purpose: turns a debounced Morse key level into up to five dot/dash slots per letter.
// Latency: a symbol appears the cycle after the first low sample; letter_done follows the last gap sample by one cycle.
// Backpressure: none; the key cannot be stalled, and a sixth symbol is dropped with an overflow strobe.
module morse_symbol_sequencer #(
   parameter int UNIT_CYCLES = 1000,
   parameter int DASH_UNITS  = 2,
   parameter int GAP_UNITS   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key,
   output logic [1:0] morse_one,
   output logic [1:0] morse_two,
   output logic [1:0] morse_three,
   output logic [1:0] morse_four,
   output logic [1:0] morse_five,
   output logic       letter_done,
   output logic [2:0] symbol_count,
   output logic       overflow,
   output logic       busy
);

   // Counters cover 7 units and every threshold, whichever is larger.
   localparam int MAX_U0  = (DASH_UNITS > 7) ? DASH_UNITS : 7;
   localparam int MAX_U   = (GAP_UNITS > MAX_U0) ? GAP_UNITS : MAX_U0;
   localparam int CNT_MAX = MAX_U * UNIT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DASH_LIM = CW'(DASH_UNITS * UNIT_CYCLES);
   localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_UNITS * UNIT_CYCLES);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] SAT      = {CW{1'b1}};

   typedef enum logic [2:0] {
      ARM,
      IDLE,
      PRESS,
      GAP,
      DONE
   } state_t;

   state_t          state;
   logic [4:0][1:0] slots;
   logic [CW-1:0]   len;
   logic [CW-1:0]   gap;
   logic [CW-1:0]   len_inc;
   logic [CW-1:0]   gap_inc;
   logic [1:0]      sym;

   // Saturating increments and the dot/dash decision from the current press length.
   assign len_inc = (len == SAT) ? len : len + ONE;
   assign gap_inc = (gap == SAT) ? gap : gap + ONE;
   assign sym     = (len >= DASH_LIM) ? 2'b10 : 2'b01;

   assign morse_one   = slots[0];
   assign morse_two   = slots[1];
   assign morse_three = slots[2];
   assign morse_four  = slots[3];
   assign morse_five  = slots[4];

   // Sequencer FSM; all outputs are registered here alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ARM;
         slots        <= '0;
         symbol_count <= 3'd0;
         letter_done  <= 1'b0;
         overflow     <= 1'b0;
         busy         <= 1'b0;
         len          <= '0;
         gap          <= '0;
      end else begin
         letter_done <= 1'b0;
         overflow    <= 1'b0;
         case (state)
            // A key held through reset must be released before anything counts.
            ARM: begin
               if (!key) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (key) begin
                  state <= PRESS;
                  len   <= ONE;
                  busy  <= 1'b1;
               end
            end
            PRESS: begin
               if (key) begin
                  len <= len_inc;
               end else begin
                  if (symbol_count < 3'd5) begin
                     for (int i = 0; i < 5; i++) begin
                        if (symbol_count == 3'(i)) begin
                           slots[i] <= sym;
                        end
                     end
                     symbol_count <= symbol_count + 3'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
                  gap <= ONE;
                  // A one-cycle gap threshold is already met by this first low sample.
                  if (GAP_LIM <= ONE) begin
                     state       <= DONE;
                     letter_done <= 1'b1;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (key) begin
                  state <= PRESS;
                  len   <= ONE;
               end else begin
                  gap <= gap_inc;
                  if (gap_inc >= GAP_LIM) begin
                     state       <= DONE;
                     letter_done <= 1'b1;
                  end
               end
            end
            // The letter was presented for one cycle; clear it and ignore the key this cycle.
            DONE: begin
               state        <= IDLE;
               slots        <= '0;
               symbol_count <= 3'd0;
               busy         <= 1'b0;
               len          <= '0;
               gap          <= '0;
            end
            default: begin
               state <= ARM;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Purpose: directed stimulus for the Morse sequencer with a letter/overflow scoreboard.
// Latency: expectations are queued per letter; the monitor checks on letter_done and overflow strobes.
// Backpressure: none; the key pattern is driven open-loop.
module tb_morse_symbol_sequencer;

   logic       clk;
   logic       reset;
   logic       key;
   logic [1:0] morse_one, morse_two, morse_three, morse_four, morse_five;
   logic       letter_done;
   logic [2:0] symbol_count;
   logic       overflow;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [9:0] slots;
      logic [2:0] cnt;
   } letter_t;

   letter_t exp_q[$];
   int      ovf_q[$];
   logic    pend_clear = 1'b0;

   morse_symbol_sequencer #(
      .UNIT_CYCLES(4),
      .DASH_UNITS (2),
      .GAP_UNITS  (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key         (key),
      .morse_one   (morse_one),
      .morse_two   (morse_two),
      .morse_three (morse_three),
      .morse_four  (morse_four),
      .morse_five  (morse_five),
      .letter_done (letter_done),
      .symbol_count(symbol_count),
      .overflow    (overflow),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] slots_now();
      return {morse_one, morse_two, morse_three, morse_four, morse_five};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive the key level for n rising-edge samples.
   task automatic hold(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         key = v;
      end
   endtask

   task automatic push_letter(input logic [9:0] s, input logic [2:0] c);
      letter_t l;
      l.slots = s;
      l.cnt   = c;
      exp_q.push_back(l);
   endtask

   // Monitor: compares every letter and overflow strobe against the queued expectations.
   always @(negedge clk) begin
      if (!reset) begin
         if (pend_clear) begin
            chk("clear_after_done", {22'd0, slots_now(), symbol_count}, 32'd0);
         end
         pend_clear = letter_done;
         if (letter_done) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_letter: got slots %0h count %0d expected none",
                        slots_now(), symbol_count);
            end else begin
               letter_t e;
               e = exp_q.pop_front();
               chk("letter_slots", {22'd0, slots_now()}, {22'd0, e.slots});
               chk("letter_count", {29'd0, symbol_count}, {29'd0, e.cnt});
            end
         end
         if (overflow) begin
            if (ovf_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_overflow: got pulse expected none");
            end else begin
               int c;
               c = ovf_q.pop_front();
               chk("overflow_count", {29'd0, symbol_count}, 32'(c));
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      key   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state with key low
      chk("rst_slots", {22'd0, slots_now()}, 32'd0);
      chk("rst_count", {29'd0, symbol_count}, 32'd0);
      chk("rst_done", {31'd0, letter_done}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // Single dot: high 3, low 12, with timing checks
      push_letter({2'b01, 8'd0}, 3'd1);
      hold(1'b1, 1);
      @(negedge clk);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      hold(1'b1, 1);
      hold(1'b0, 1);
      @(negedge clk);
      chk("slot_visible", {30'd0, morse_one}, 32'd1);
      chk("count_visible", {29'd0, symbol_count}, 32'd1);
      hold(1'b0, 10);
      chk("no_done_at_11", {31'd0, letter_done}, 32'd0);
      @(negedge clk);
      chk("done_at_12", {31'd0, letter_done}, 32'd1);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, letter_done}, 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      hold(1'b0, 3);

      // Dash, dot, dot
      push_letter({2'b10, 2'b01, 2'b01, 4'd0}, 3'd3);
      hold(1'b1, 8);  hold(1'b0, 4);
      hold(1'b1, 3);  hold(1'b0, 4);
      hold(1'b1, 7);  hold(1'b0, 12);
      hold(1'b0, 3);

      // Thresholds: 7 high is a dot, 8 high a dash, 11 low keeps the letter
      push_letter({2'b01, 2'b10, 6'd0}, 3'd2);
      hold(1'b1, 7);  hold(1'b0, 11);
      hold(1'b1, 8);  hold(1'b0, 12);
      hold(1'b0, 3);

      // Six dots: sixth is discarded with an overflow strobe
      push_letter({5{2'b01}}, 3'd5);
      ovf_q.push_back(5);
      for (int i = 0; i < 6; i++) begin
         hold(1'b1, 2);
         hold(1'b0, (i == 5) ? 12 : 4);
      end
      hold(1'b0, 3);

      // Reset mid-letter with the key held through and after reset
      hold(1'b1, 3);  hold(1'b0, 4);
      hold(1'b1, 5);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      hold(1'b1, 10);
      chk("arm_busy", {31'd0, busy}, 32'd0);
      chk("arm_count", {29'd0, symbol_count}, 32'd0);
      chk("arm_slot", {30'd0, morse_one}, 32'd0);
      push_letter({2'b01, 8'd0}, 3'd1);
      hold(1'b0, 2);
      hold(1'b1, 3);  hold(1'b0, 12);
      hold(1'b0, 5);

      chk("letters_left", 32'(exp_q.size()), 32'd0);
      chk("overflows_left", 32'(ovf_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
